// File: rtl/ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// ahb_master_arbiter
//
// Two-master AHB-lite address-phase arbiter: the CPU (master 0, default/parking
// master) and the DMA controller (master 1). Ownership only moves on transfer
// or burst boundaries. A DMA tenure limit guarantees that a waiting CPU gets
// the bus at the next DMA burst boundary once MAX_TENURE beats have been
// accepted. After such a forced handover the DMA stays ineligible until the
// CPU has completed one transfer or withdrawn its request.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : rotating priority; the master that most recently released the
//               bus loses a simultaneous request at the next boundary.
//   undefined : fixed priority, DMA over CPU (tenure limit / starve lock still
//               apply in both builds).
//
// Parameters
//   MAX_TENURE   accepted DMA beats before a pending CPU request forces
//                handover at the next DMA burst boundary (1..255)
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous, active-high reset
//   CpuReq       CPU bus request
//   CpuTrans     CPU HTRANS (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   DmaReq       DMAC Bus_Req
//   MTrans       DMAC HTRANS
//   MBurst_Size  DMAC burst length in beats, sampled on NONSEQ (0 and 1 = one)
//   HReady       bus ready; HReady=0 freezes all state
//   CpuGrant     CPU owns the address phase
//   Bus_Grant    DMAC owns the address phase
//   HMaster      address-phase owner index (0 CPU, 1 DMA)
//   HMasterD     data-phase owner index
// -----------------------------------------------------------------------------
module ahb_master_arbiter #(
   parameter int unsigned MAX_TENURE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       CpuReq,
   input  logic [1:0] CpuTrans,
   input  logic       DmaReq,
   input  logic [1:0] MTrans,
   input  logic [3:0] MBurst_Size,
   input  logic       HReady,
   output logic       CpuGrant,
   output logic       Bus_Grant,
   output logic       HMaster,
   output logic       HMasterD
);

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } arb_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [7:0] TENURE_LIMIT  = 8'(MAX_TENURE);

   // Burst length as the DMA announces it; a size of 0 is a single beat.
   function automatic logic [3:0] burst_len_of(input logic [3:0] size);
      return (size == 4'd0) ? 4'd1 : size;
   endfunction

   // Tenure counter saturates instead of wrapping so a very long DMA tenure
   // can never look short again.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // State registers
   arb_state_e state_q, state_d;
   logic       hmaster_d_q, hmaster_d_d;
   logic [3:0] beat_cnt_q, beat_cnt_d;
   logic [3:0] burst_len_q, burst_len_d;
   logic [7:0] tenure_q, tenure_d;
   logic       starve_lock_q, starve_lock_d;
`ifdef ARB_ROUND_ROBIN_EN
   // Master that most recently gave the bus away (0 CPU, 1 DMA).
   logic       last_rel_q, last_rel_d;
`endif

   // Decode signals
   logic       cpu_acc;
   logic       dma_acc;
   logic       dma_nonseq;
   logic [3:0] cur_len;
   logic [4:0] cur_idx;
   logic       last_beat;
   logic       cpu_bnd;
   logic       dma_bnd;
   logic [7:0] tenure_inc;
   logic       tenure_hit;
   logic       lock_clr;
   logic       dma_elig;
   logic       dma_wins;
   logic       release_cpu;
   logic       release_dma;
   logic       forced_handover;

   always_comb begin
      // Accepted beats; only the address-phase owner can have one accepted.
      cpu_acc    = (state_q == CPU_OWN) && HReady && CpuTrans[1];
      dma_acc    = (state_q == DMA_OWN) && HReady && MTrans[1];
      dma_nonseq = (MTrans == HTRANS_NONSEQ);

      // Index/length of the beat on the bus now. A NONSEQ is always beat 0 of a
      // fresh burst, regardless of any count still in flight.
      cur_len = dma_nonseq ? burst_len_of(MBurst_Size) : burst_len_q;
      cur_idx = dma_nonseq ? 5'd0 : ({1'b0, beat_cnt_q} + 5'd1);
      last_beat = dma_acc && (cur_idx == ({1'b0, cur_len} - 5'd1));

      cpu_bnd = !CpuReq || (CpuTrans == HTRANS_IDLE) || cpu_acc;
      dma_bnd = !DmaReq || (MTrans == HTRANS_IDLE) || last_beat;

      // The limit is judged on the count including the beat being accepted,
      // so the MAX_TENURE-th beat itself can trigger the handover.
      tenure_inc = dma_acc ? sat_inc8(tenure_q) : tenure_q;
      tenure_hit = (tenure_inc >= TENURE_LIMIT);

      // The lock clears in the same cycle the CPU completes a transfer or
      // withdraws, so the DMA can be granted on that very edge.
      lock_clr = HReady && (!CpuReq || cpu_acc);
      dma_elig = DmaReq && (!starve_lock_q || lock_clr);

`ifdef ARB_ROUND_ROBIN_EN
      // On simultaneous requests the master that did not release last wins.
      dma_wins = dma_elig && (!CpuReq || !last_rel_q);
`else
      dma_wins = dma_elig;
`endif

      release_cpu = HReady && (state_q == CPU_OWN) && cpu_bnd && dma_wins;
      release_dma = HReady && (state_q == DMA_OWN) && dma_bnd &&
                    (!DmaReq || (CpuReq && tenure_hit));
      forced_handover = release_dma && DmaReq && CpuReq && tenure_hit;

      // Next-state defaults: hold everything.
      state_d       = state_q;
      hmaster_d_d   = hmaster_d_q;
      beat_cnt_d    = beat_cnt_q;
      burst_len_d   = burst_len_q;
      tenure_d      = tenure_inc;
      starve_lock_d = starve_lock_q;
`ifdef ARB_ROUND_ROBIN_EN
      last_rel_d    = last_rel_q;
`endif

      case (state_q)
         CPU_OWN: if (release_cpu) state_d = DMA_OWN;
         DMA_OWN: if (release_dma) state_d = CPU_OWN;
         default: state_d = CPU_OWN;
      endcase

      if (release_cpu) begin
         tenure_d = 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
         last_rel_d = 1'b0;
`endif
      end
`ifdef ARB_ROUND_ROBIN_EN
      if (release_dma) last_rel_d = 1'b1;
`endif

      if (dma_acc) begin
         if (dma_nonseq) begin
            burst_len_d = cur_len;
            beat_cnt_d  = 4'd0;
         end else begin
            beat_cnt_d  = beat_cnt_q + 4'd1;
         end
      end

      if (lock_clr)        starve_lock_d = 1'b0;
      if (forced_handover) starve_lock_d = 1'b1;

      // Data phase follows the address phase by one accepted (HReady) cycle.
      if (HReady) hmaster_d_d = (state_q == DMA_OWN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= CPU_OWN;
         hmaster_d_q   <= 1'b0;
         beat_cnt_q    <= 4'd0;
         burst_len_q   <= 4'd1;
         tenure_q      <= 8'd0;
         starve_lock_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_rel_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         hmaster_d_q   <= hmaster_d_d;
         beat_cnt_q    <= beat_cnt_d;
         burst_len_q   <= burst_len_d;
         tenure_q      <= tenure_d;
         starve_lock_q <= starve_lock_d;
`ifdef ARB_ROUND_ROBIN_EN
         last_rel_q    <= last_rel_d;
`endif
      end
   end

   assign Bus_Grant = (state_q == DMA_OWN);
   assign CpuGrant  = (state_q == CPU_OWN);
   assign HMaster   = (state_q == DMA_OWN);
   assign HMasterD  = hmaster_d_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ahb_master_arbiter
//
// Directed bench for ahb_master_arbiter (MAX_TENURE = 4). Outputs are packed
// as {CpuGrant, Bus_Grant, HMaster, HMasterD} and compared after each edge.
// -----------------------------------------------------------------------------
module tb_ahb_master_arbiter;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;

   // Packed output patterns {CpuGrant, Bus_Grant, HMaster, HMasterD}
   localparam logic [3:0] O_CPU   = 4'b1000; // CPU owns, data phase CPU
   localparam logic [3:0] O_CPU_D = 4'b1001; // CPU owns, data phase DMA
   localparam logic [3:0] O_DMA   = 4'b0111; // DMA owns, data phase DMA
   localparam logic [3:0] O_DMA_C = 4'b0110; // DMA owns, data phase CPU

   logic       clk;
   logic       rst;
   logic       CpuReq;
   logic [1:0] CpuTrans;
   logic       DmaReq;
   logic [1:0] MTrans;
   logic [3:0] MBurst_Size;
   logic       HReady;
   logic       CpuGrant;
   logic       Bus_Grant;
   logic       HMaster;
   logic       HMasterD;

   int n_checks = 0;
   int n_errors = 0;

   ahb_master_arbiter #(.MAX_TENURE(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .CpuReq     (CpuReq),
      .CpuTrans   (CpuTrans),
      .DmaReq     (DmaReq),
      .MTrans     (MTrans),
      .MBurst_Size(MBurst_Size),
      .HReady     (HReady),
      .CpuGrant   (CpuGrant),
      .Bus_Grant  (Bus_Grant),
      .HMaster    (HMaster),
      .HMasterD   (HMasterD)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b, expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] outs();
      return {4'b0000, CpuGrant, Bus_Grant, HMaster, HMasterD};
   endfunction

   // One clock, then settle so outputs are sampled away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; CpuReq = 1'b0; CpuTrans = IDLE; DmaReq = 1'b0;
      MTrans = IDLE; MBurst_Size = 4'd0; HReady = 1'b1;
      #1;
      step();
      step();
      chk("reset", outs(), {4'b0, O_CPU});
      rst = 1'b0;

      // Idle bus parks on the CPU
      for (int i = 0; i < 5; i++) begin
         step();
         chk("idle", outs(), {4'b0, O_CPU});
      end

      // DMA request on an idle bus: grant after one edge, data phase one later
      DmaReq = 1'b1;
      step();
      chk("dma_grant", outs(), {4'b0, O_DMA_C});
      step();
      chk("hmasterd_lag", outs(), {4'b0, O_DMA});

      // 4-beat burst, CPU requests mid-burst, tenure limit 4
      MTrans = NONSEQ; MBurst_Size = 4'd4;
      step();
      chk("t_beat0", outs(), {4'b0, O_DMA});
      MTrans = SEQ;
      step();
      chk("t_beat1", outs(), {4'b0, O_DMA});
      CpuReq = 1'b1; CpuTrans = NONSEQ;
      step();
      chk("t_beat2", outs(), {4'b0, O_DMA});
      step();
      chk("tenure_handover", outs(), {4'b0, O_CPU_D});
      // CPU at a boundary but no transfer done: starve lock keeps DMA out
      MTrans = IDLE; CpuTrans = IDLE;
      step();
      chk("starve_lock_hold", outs(), {4'b0, O_CPU});
      // CPU transfer accepted: lock released
      CpuTrans = NONSEQ;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("lock_release", outs(), {4'b0, O_CPU});
`else
      chk("lock_release", outs(), {4'b0, O_DMA_C});
`endif
      CpuReq = 1'b0; CpuTrans = IDLE;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("dma_regrant", outs(), {4'b0, O_DMA_C});
`else
      chk("dma_regrant", outs(), {4'b0, O_DMA});
`endif
      step();
      chk("dma_settle", outs(), {4'b0, O_DMA});

      // HReady stall during the last beat with the CPU waiting
      CpuReq = 1'b1; CpuTrans = NONSEQ;
      MTrans = NONSEQ; MBurst_Size = 4'd4;
      step();
      chk("s_beat0", outs(), {4'b0, O_DMA});
      MTrans = SEQ;
      step();
      chk("s_beat1", outs(), {4'b0, O_DMA});
      step();
      chk("s_beat2", outs(), {4'b0, O_DMA});
      HReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hready_freeze", outs(), {4'b0, O_DMA});
      end
      HReady = 1'b1;
      step();
      chk("stall_handover", outs(), {4'b0, O_CPU_D});
      MTrans = IDLE; CpuReq = 1'b0; DmaReq = 1'b0; CpuTrans = IDLE;
      step();
      chk("stall_idle", outs(), {4'b0, O_CPU});

      // Simultaneous requests on an idle bus after a DMA tenure
      CpuReq = 1'b1; CpuTrans = NONSEQ; DmaReq = 1'b1;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("simultaneous", outs(), {4'b0, O_CPU});
`else
      chk("simultaneous", outs(), {4'b0, O_DMA_C});
`endif
      CpuReq = 1'b0; CpuTrans = IDLE; DmaReq = 1'b0;
      step();
`ifdef ARB_ROUND_ROBIN_EN
      chk("both_drop", outs(), {4'b0, O_CPU});
`else
      chk("both_drop", outs(), {4'b0, O_CPU_D});
`endif
      step();
      chk("back_to_idle", outs(), {4'b0, O_CPU});

      // Reset in the middle of an 8-beat burst
      DmaReq = 1'b1;
      step();
      chk("r_grant", outs(), {4'b0, O_DMA_C});
      MTrans = NONSEQ; MBurst_Size = 4'd8;
      step();
      chk("r_beat0", outs(), {4'b0, O_DMA});
      MTrans = SEQ;
      step();
      chk("r_beat1", outs(), {4'b0, O_DMA});
      rst = 1'b1;
      step();
      chk("reset_mid_burst", outs(), {4'b0, O_CPU});
      rst = 1'b0; MTrans = IDLE;
      step();
      chk("post_reset_grant", outs(), {4'b0, O_DMA_C});
      // Fresh 8-beat burst must complete before the waiting CPU gets the bus
      CpuReq = 1'b1; CpuTrans = NONSEQ;
      MTrans = NONSEQ; MBurst_Size = 4'd8;
      step();
      chk("b8_beat0", outs(), {4'b0, O_DMA});
      MTrans = SEQ;
      for (int i = 1; i < 7; i++) begin
         step();
         chk("b8_beat_hold", outs(), {4'b0, O_DMA});
      end
      step();
      chk("burst8_handover", outs(), {4'b0, O_CPU_D});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
